ps2_keycode_rx: RTL and testbench
=================================

PS2_KEYCODE_RX -- requirements
Module: ps2_keycode_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8, meaning consecutive identical samples required before the filtered PS/2 clock changes.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100_000, meaning the maximum clk cycles allowed between falling edges inside one frame.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ps2_clk  input  1  raw keyboard clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  raw keyboard data, asynchronous to clk.
REQ-007 SHALL have port keycode  output  16  [15:8] = previous accepted byte, [7:0] = latest accepted byte.
REQ-008 SHALL have port keycode_valid  output  1  one-cycle pulse when keycode updates.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit or a timeout.
REQ-010 SHALL have port parity_err  output  1  one-cycle pulse on an odd-parity failure.

Function
REQ-011 SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer before any use.
REQ-012 SHALL change the filtered clock only after FILTER_LEN consecutive equal synchronized samples that differ from its current value; shorter glitches SHALL be ignored.
REQ-013 SHALL detect a falling edge when the filtered clock goes 1->0, and SHALL sample synchronized ps2_data in that same cycle.
REQ-014 SHALL implement FSM states IDLE, DATA, PARITY, STOP, with a 3-bit bit counter.
REQ-015 In IDLE, a falling edge with data=0 SHALL move the FSM to DATA and clear the counter; data=1 SHALL be ignored.
REQ-016 DATA SHALL shift in 8 bits LSB first, one per falling edge, and SHALL move to PARITY after counter value 7.
REQ-017 PARITY SHALL capture the parity bit on the next edge and then move to STOP.
REQ-018 STOP SHALL go to IDLE on the next edge.
  - data=1 with parity OK: the byte is accepted.
  - data=0: the byte is discarded and frame_err pulses.
REQ-019 Parity SHALL be odd: the XOR of the 8 data bits and the parity bit equals 1.
REQ-020 On accept, keycode SHALL become {keycode[7:0], byte} and keycode_valid SHALL pulse, both in the cycle after the stop-bit edge (latency 1 clk).
REQ-021 keycode SHALL hold its value between accepts; 0xF0 (break) and 0xE0 (extended) bytes SHALL be shifted in like any other byte.
REQ-022 A timeout counter SHALL clear on every falling edge and SHALL count while the FSM is not in IDLE.
REQ-023 When the timeout counter reaches TIMEOUT_CYCLES, the FSM SHALL return to IDLE, frame_err SHALL pulse, the partial byte SHALL be dropped, and keycode SHALL stay unchanged.
REQ-024 If a timeout and an edge occur in the same cycle, the edge SHALL take priority and no timeout SHALL be flagged.
REQ-025 At most one of keycode_valid, frame_err and parity_err SHALL be high in any cycle.

Reset
REQ-026 rst SHALL set keycode=16'h0000, keycode_valid=0, frame_err=0, parity_err=0, FSM=IDLE, counters=0, and synchronizers and filtered clock=1.
REQ-027 A reset during a frame SHALL discard the partial frame; decoding SHALL restart only at the next start bit.

Configuration
REQ-028 Macro PS2_PARITY_CHECK_EN defined: a parity failure SHALL discard the byte and pulse parity_err instead of keycode_valid.
REQ-029 Macro PS2_PARITY_CHECK_EN undefined: parity SHALL be ignored, the byte accepted on a good stop bit, and parity_err tied to 0.

Verification
REQ-030 Frame 0x1D (bits 1,0,1,1,1,0,0,0; parity 1; stop 1) after reset -> keycode=0x001D, one keycode_valid pulse.
REQ-031 Frames 0xF0, then 0x1D -> keycode=0x1DF0, then keycode=0xF01D; two keycode_valid pulses.
REQ-032 Frame 0x23 sent with parity 1 (bad) -> with the macro: keycode unchanged, parity_err pulse; without the macro: keycode[7:0]=0x23.
REQ-033 A 3-cycle low glitch on ps2_clk (FILTER_LEN=8) during IDLE, then frame 0x1C -> no spurious bit, keycode[7:0]=0x1C.
REQ-034 Five bits sent, then idle for TIMEOUT_CYCLES -> frame_err pulse, FSM in IDLE; a following 0x1C frame decodes correctly.
REQ-035 rst asserted after 4 data bits, then a full 0x1B frame -> keycode=0x001B, no error pulses.

Source files
------------

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the keyboard lines, decodes
// 11-bit frames and keeps the last two bytes. Optional macro: PS2_PARITY_CHECK_EN.
module ps2_keycode_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [15:0] keycode,
   output logic        keycode_valid,
   output logic        frame_err,
   output logic        parity_err
);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);

   state_t        state_q, state_d;
   logic [1:0]    clk_sync, data_sync;
   logic          filt_clk, filt_prev;
   logic [FW-1:0] filt_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_q;
   logic [TW-1:0] tmo_cnt;
   logic          fall, ps2_d;
   logic          accept, stop_bad, parity_bad, timeout;

   assign ps2_d = data_sync[1];
   assign fall  = filt_prev & ~filt_clk;

   // Idle-high lines: synchronizers and filter come out of reset as released bus.
   // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         filt_clk  <= 1'b1;
         filt_prev <= 1'b1;
         filt_cnt  <= '0;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         filt_prev <= filt_clk;
         if (clk_sync[1] == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FILT_MAX) begin
            filt_clk <= clk_sync[1];
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

`ifdef PS2_PARITY_CHECK_EN
   logic par_bit;
   logic parity_ok;
   assign parity_ok = ^{shift_q, par_bit};

   always_ff @(posedge clk) begin
      if (rst)
         par_bit <= 1'b0;
      else if (fall && state_q == PARITY)
         par_bit <= ps2_d;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: every signal assigned here gets a default first so no latch can be inferred.
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      stop_bad   = 1'b0;
      parity_bad = 1'b0;
      timeout    = 1'b0;
      if (fall) begin
         // A falling edge always wins over a timeout expiring in the same cycle.
         case (state_q)
            IDLE:   if (!ps2_d) state_d = DATA;
            DATA:   if (bit_cnt == 3'd7) state_d = PARITY;
            PARITY: state_d = STOP;
            STOP: begin
               state_d = IDLE;
               if (ps2_d) begin
`ifdef PS2_PARITY_CHECK_EN
                  if (parity_ok) accept = 1'b1;
                  else           parity_bad = 1'b1;
`else
                  accept = 1'b1;
`endif
               end else begin
                  stop_bad = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE && tmo_cnt == TMO_MAX) begin
         timeout = 1'b1;
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt       <= '0;
         shift_q       <= '0;
         tmo_cnt       <= '0;
         keycode       <= '0;
         keycode_valid <= 1'b0;
         frame_err     <= 1'b0;
      end else begin
         if (fall && state_q == IDLE) begin
            bit_cnt <= '0;
         end else if (fall && state_q == DATA) begin
            shift_q <= {ps2_d, shift_q[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end

         if (fall || state_q == IDLE) tmo_cnt <= '0;
         else                         tmo_cnt <= tmo_cnt + 1'b1;

         if (accept) keycode <= {keycode[7:0], shift_q};
         keycode_valid <= accept;
         frame_err     <= stop_bad | timeout;
      end
   end

`ifdef PS2_PARITY_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) parity_err <= 1'b0;
      else     parity_err <= parity_bad;
   end
`else
   assign parity_err = 1'b0;
   logic unused_parity;
   assign unused_parity = parity_bad;
`endif

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx: expected output pulses are queued as frames are
// driven and compared by a monitor whenever the receiver pulses.
module tb_ps2_keycode_rx;

   localparam int FL   = 8;
   localparam int TMO  = 1000;
   localparam int HALF = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [15:0] keycode;
   logic        keycode_valid, frame_err, parity_err;

   ps2_keycode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .keycode(keycode), .keycode_valid(keycode_valid),
      .frame_err(frame_err), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   // pulses = {keycode_valid, frame_err, parity_err}
   typedef struct {
      logic [2:0]  pulses;
      logic [15:0] kc;
   } ev_t;

   ev_t         sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] kc_model = 16'h0000;
   logic [2:0]  mon_pulses;
   ev_t         mon_ev;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      mon_pulses = {keycode_valid, frame_err, parity_err};
      if (!rst && mon_pulses != 3'b000) begin
         check("onehot_pulses", $countones(mon_pulses), 1);
         if (sb.size() == 0) begin
            check("unexpected_pulse", {29'd0, mon_pulses}, 0);
         end else begin
            mon_ev = sb.pop_front();
            check("pulse_kind", {29'd0, mon_pulses}, {29'd0, mon_ev.pulses});
            check("pulse_keycode", {16'd0, keycode}, {16'd0, mon_ev.kc});
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic odd_par(input logic [7:0] b);
      return ~^b;
   endfunction

   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                             input int nbits);
      logic [10:0] bits;
      bits = {stop, par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = bits[i];
         tick(HALF);
         ps2_clk = 1'b0;
         tick(HALF);
         ps2_clk = 1'b1;
      end
      tick(HALF);
      ps2_data = 1'b1;
   endtask

   task automatic expect_accept(input logic [7:0] b);
      kc_model = {kc_model[7:0], b};
      sb.push_back('{3'b100, kc_model});
   endtask

   task automatic drain(input string tag, input int budget);
      int i;
      i = 0;
      while (sb.size() != 0 && i < budget) begin
         tick(1);
         i++;
      end
      check(tag, sb.size(), 0);
      sb.delete();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_keycode"}, {16'd0, keycode}, 0);
      check({tag, "_valid"}, {31'd0, keycode_valid}, 0);
      check({tag, "_frame_err"}, {31'd0, frame_err}, 0);
      check({tag, "_parity_err"}, {31'd0, parity_err}, 0);
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      tick(5);
      check_reset_state("reset");
      rst = 1'b0;
      tick(10);

      // Single frame 0x1D
      expect_accept(8'h1D);
      send_frame(8'h1D, odd_par(8'h1D), 1'b1, 11);
      drain("drain_1d", 100);
      check("kc_001d", {16'd0, keycode}, 32'h001D);

      // Break code then 0x1D
      expect_accept(8'hF0);
      send_frame(8'hF0, odd_par(8'hF0), 1'b1, 11);
      drain("drain_f0", 100);
      check("kc_1df0", {16'd0, keycode}, 32'h1DF0);
      expect_accept(8'h1D);
      send_frame(8'h1D, odd_par(8'h1D), 1'b1, 11);
      drain("drain_1d_2", 100);
      check("kc_f01d", {16'd0, keycode}, 32'hF01D);

      // Bad parity on 0x23
`ifdef PS2_PARITY_CHECK_EN
      sb.push_back('{3'b001, kc_model});
`else
      expect_accept(8'h23);
`endif
      send_frame(8'h23, ~odd_par(8'h23), 1'b1, 11);
      drain("drain_parity", 100);
      check("kc_after_parity", {16'd0, keycode}, {16'd0, kc_model});

      // Short low glitch while idle must not start a frame
      ps2_clk = 1'b0;
      tick(3);
      ps2_clk = 1'b1;
      tick(40);
      check("kc_hold_glitch", {16'd0, keycode}, {16'd0, kc_model});
      expect_accept(8'h1C);
      send_frame(8'h1C, odd_par(8'h1C), 1'b1, 11);
      drain("drain_glitch_1c", 100);
      check("kc_lo_1c", {24'd0, keycode[7:0]}, 32'h1C);

      // Bad stop bit
      sb.push_back('{3'b010, kc_model});
      send_frame(8'h55, odd_par(8'h55), 1'b0, 11);
      drain("drain_stop", 100);
      check("kc_hold_stop", {16'd0, keycode}, {16'd0, kc_model});

      // Timeout after five bits, then a clean frame
      sb.push_back('{3'b010, kc_model});
      send_frame(8'h3A, odd_par(8'h3A), 1'b1, 5);
      drain("drain_timeout", TMO + 300);
      check("kc_hold_timeout", {16'd0, keycode}, {16'd0, kc_model});
      expect_accept(8'h1C);
      send_frame(8'h1C, odd_par(8'h1C), 1'b1, 11);
      drain("drain_post_tmo", 100);
      check("kc_post_tmo", {16'd0, keycode}, {16'd0, kc_model});

      // Reset after four data bits discards the frame and clears keycode
      send_frame(8'h77, odd_par(8'h77), 1'b1, 5);
      rst = 1'b1;
      tick(3);
      check_reset_state("midreset");
      rst = 1'b0;
      kc_model = 16'h0000;
      tick(20);
      expect_accept(8'h1B);
      send_frame(8'h1B, odd_par(8'h1B), 1'b1, 11);
      drain("drain_1b", 100);
      check("kc_001b", {16'd0, keycode}, 32'h001B);

      tick(50);
      check("kc_final_hold", {16'd0, keycode}, 32'h001B);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
